// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO burst reader: FSM state encoding and skid buffer depth.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_e;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order word buffer; slot0 is always the head, simultaneous write/read keeps FIFO order.
module stream_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd,
  output logic [SKID_CNT_W-1:0] count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic                  rd_ok;
  logic [SKID_CNT_W-1:0] wr_idx;

  assign rd_ok  = rd && (count != '0);
  assign wr_idx = rd_ok ? count - SKID_CNT_W'(1) : count;
  assign head   = slot0;

  // Shift on read first; a write landing in slot0 in the same cycle overrides the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else begin
      if (rd_ok) slot0 <= slot1;
      if (wr) begin
        if (wr_idx == '0) slot0 <= wr_data;
        else              slot1 <= wr_data;
      end
      count <= count + SKID_CNT_W'(wr) - SKID_CNT_W'(rd_ok);
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Command-driven FIFO drain engine with valid/ready output through a 2-entry skid buffer.
// Optional m_last output enabled by defining FIFO_RD_LAST_EN.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_ready,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  beats_left
`ifdef FIFO_RD_LAST_EN
  ,
  output logic                  m_last
`endif
);

  localparam logic [SKID_CNT_W-1:0] DEPTH_C = SKID_CNT_W'(SKID_DEPTH);

  rd_state_e             state, state_nxt;
  logic [LEN_WIDTH-1:0]  issue_cnt;
  logic                  rd_pend;
  logic [SKID_CNT_W-1:0] buf_cnt;
  logic [SKID_CNT_W-1:0] occ;
  logic                  room;
  logic                  hs;
  logic                  last_beat;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (rd_pend),
    .wr_data (fifo_rd_data),
    .rd      (hs),
    .count   (buf_cnt),
    .head    (m_data)
  );

  assign m_valid   = (buf_cnt != '0);
  assign hs        = m_valid && m_ready;
  assign last_beat = (beats_left == LEN_WIDTH'(1));

  // Occupancy includes the word still in flight from the FIFO register.
  assign occ  = buf_cnt + SKID_CNT_W'(rd_pend);
  assign room = (occ < DEPTH_C) || ((occ == DEPTH_C) && hs);

`ifdef FIFO_RD_LAST_EN
  assign m_last = m_valid && last_beat;
`endif

  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_len == '0) ? DONE : RUN;
      end
      RUN: begin
        busy       = 1'b1;
        fifo_rd_en = (issue_cnt != '0) && !fifo_empty && room;
        if (hs && last_beat) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      beats_left <= '0;
      rd_pend    <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_pend <= fifo_rd_en;
      if (state == IDLE) begin
        if (cmd_valid && (cmd_len != '0)) begin
          issue_cnt  <= cmd_len;
          beats_left <= cmd_len;
        end
      end else begin
        if (fifo_rd_en) issue_cnt  <= issue_cnt - LEN_WIDTH'(1);
        if (hs)         beats_left <= beats_left - LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: FIFO model with registered read plus an output scoreboard.
module tb_fifo_burst_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_ready;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [LW-1:0] beats_left;
`ifdef FIFO_RD_LAST_EN
  logic          m_last;
`endif

  fifo_burst_reader #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_len      (cmd_len),
    .cmd_ready    (cmd_ready),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .busy         (busy),
    .done         (done),
    .beats_left   (beats_left)
`ifdef FIFO_RD_LAST_EN
    ,
    .m_last       (m_last)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: bench writes via wptr, the read port advances rptr with one-cycle read latency.
  logic [DW-1:0] fmem [0:255];
  int unsigned   wptr = 0;
  int unsigned   rptr = 0;
  int unsigned   hs_cnt = 0;
  assign fifo_empty = (wptr == rptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd_data <= '0;
    end else begin
      if (fifo_rd_en && !fifo_empty) begin
        fifo_rd_data <= fmem[rptr[7:0]];
        rptr         <= rptr + 1;
      end
      if (m_valid && m_ready) hs_cnt <= hs_cnt + 1;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  logic [DW-1:0] exp_q[$];
  int            tb_left = 0;
  logic          track = 1'b0;
  int unsigned   p_base = 0;
  int unsigned   h_base = 0;
  int unsigned   max_out = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_rd_en && fifo_empty) chk("overpop", 32'(1), 32'(0));
      if (track && ((rptr - p_base) - (hs_cnt - h_base)) > max_out)
        max_out = (rptr - p_base) - (hs_cnt - h_base);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", 32'(m_data), 32'hFFFF_FFFF);
        else chk("data", 32'(m_data), 32'(exp_q.pop_front()));
        chk("beats_left", 32'(beats_left), 32'(tb_left));
`ifdef FIFO_RD_LAST_EN
        chk("m_last", 32'(m_last), 32'(tb_left == 1));
`endif
        tb_left = tb_left - 1;
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] v, input logic expect_out);
    fmem[wptr[7:0]] = v;
    wptr = wptr + 1;
    if (expect_out) exp_q.push_back(v);
  endtask

  task automatic issue_cmd(input int len);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_len   = LW'(len);
    @(posedge clk);
    tb_left = len;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'(0));
    chk({tag, "_m_valid"}, 32'(m_valid), 32'(0));
    chk({tag, "_m_data"}, 32'(m_data), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_beats_left"}, 32'(beats_left), 32'(0));
`ifdef FIFO_RD_LAST_EN
    chk({tag, "_m_last"}, 32'(m_last), 32'(0));
`endif
  endtask

  initial begin
    int unsigned p0;
    int unsigned h0;
    logic [3:0]  rdy_pat;
    logic        seen;

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Burst of 4 with m_ready high: first beat at T+3, back-to-back beats, done at T+7.
    for (int i = 0; i < 4; i++) push_word(DW'(8'h10 + i), 1'b1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_len   = LW'(4);
    @(posedge clk);
    tb_left = 4;
    p0 = rptr;
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'(1));
    chk("t1_first_pop", 32'(fifo_rd_en), 32'(1));
    chk("t1_cmd_ready_run", 32'(cmd_ready), 32'(0));
    @(negedge clk);
    chk("t1_valid_t2", 32'(m_valid), 32'(0));
    @(negedge clk);
    chk("t1_valid_t3", 32'(m_valid), 32'(1));
    chk("t1_head_t3", 32'(m_data), 32'(8'h10));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_stream", 32'(m_valid), 32'(1));
      chk("t1_no_done", 32'(done), 32'(0));
    end
    @(negedge clk);
    chk("t1_done", 32'(done), 32'(1));
    chk("t1_pops", rptr - p0, 32'(4));
    @(negedge clk);
    chk("t1_done_clr", 32'(done), 32'(0));
    chk("t1_cmd_ready", 32'(cmd_ready), 32'(1));

    // Zero-length command: no pop even with data available.
    push_word(DW'(8'hAA), 1'b0);
    p0 = rptr;
    issue_cmd(0);
    @(negedge clk);
    chk("z_done", 32'(done), 32'(1));
    chk("z_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("z_rd_en", 32'(fifo_rd_en), 32'(0));
    @(negedge clk);
    chk("z_cmd_ready_back", 32'(cmd_ready), 32'(1));
    chk("z_done_clr", 32'(done), 32'(0));
    chk("z_pops", rptr - p0, 32'(0));
    wptr = rptr;

    // 8-word burst under 1,0,0,1 backpressure.
    for (int i = 0; i < 8; i++) push_word(DW'(8'h40 + 3 * i), 1'b1);
    p_base = rptr;
    h_base = hs_cnt;
    track  = 1'b1;
    issue_cmd(8);
    rdy_pat = 4'b1001;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      m_ready = rdy_pat[c % 4];
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    track = 1'b0;
    chk("bp_done", 32'(seen), 32'(1));
    chk("bp_pops", rptr - p_base, 32'(8));
    chk("bp_beats", hs_cnt - h_base, 32'(8));
    chk("bp_max_outstanding", max_out, 32'(2));
    chk("bp_exp_empty", 32'(exp_q.size()), 32'(0));
    @(posedge clk); #1 m_ready = 1'b1;

    // Starved FIFO: 2 of 5 words present, stall, then remaining 3 arrive.
    push_word(DW'(8'hA1), 1'b1);
    push_word(DW'(8'hA2), 1'b1);
    h0 = hs_cnt;
    p0 = rptr;
    issue_cmd(5);
    repeat (20) @(negedge clk);
    chk("st_busy", 32'(busy), 32'(1));
    chk("st_beats", hs_cnt - h0, 32'(2));
    chk("st_beats_left", 32'(beats_left), 32'(3));
    chk("st_rd_en", 32'(fifo_rd_en), 32'(0));
    for (int i = 0; i < 3; i++) push_word(DW'(8'hA3 + i), 1'b1);
    wait_done("st_done", 50);
    chk("st_total", hs_cnt - h0, 32'(5));
    chk("st_pops", rptr - p0, 32'(5));

    // Reset asserted after 3 beats of a 6-word burst.
    for (int i = 0; i < 6; i++) push_word(DW'(8'hC0 + i), 1'b1);
    h0 = hs_cnt;
    issue_cmd(6);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (hs_cnt - h0 >= 3) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_reach3", 32'(seen), 32'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    wptr = rptr;
    tb_left = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_word(DW'(8'h5A), 1'b1);
    push_word(DW'(8'hA5), 1'b1);
    h0 = hs_cnt;
    issue_cmd(2);
    wait_done("rst_new_done", 40);
    chk("rst_new_beats", hs_cnt - h0, 32'(2));

    // cmd_valid held through RUN with changing cmd_len: only the first burst runs.
    @(negedge clk);
    for (int i = 0; i < 3; i++) push_word(DW'(8'h70 + i), 1'b1);
    h0 = hs_cnt;
    p0 = rptr;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_len   = LW'(3);
    @(posedge clk);
    tb_left = 3;
    #1 cmd_len = LW'(7);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    chk("hold_done", 32'(seen), 32'(1));
    chk("hold_beats", hs_cnt - h0, 32'(3));
    chk("hold_pops", rptr - p0, 32'(3));
    @(negedge clk);
    chk("hold_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("hold_busy", 32'(busy), 32'(0));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Command-driven drain engine for the block-RAM FIFO's read port. On a length command it pops exactly that many words from the FIFO and presents them on a valid/ready output stream, absorbing the FIFO's one-cycle registered read latency and downstream backpressure with a 2-entry skid buffer. It sits between the capture FIFO and the upload/serializer path.

## Interface
- DATA_WIDTH, 8, word width; must match the FIFO.
- LEN_WIDTH, 16, width of burst length and beat counter.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  burst request.
- cmd_len  in  LEN_WIDTH  words to transfer, sampled when cmd_valid && cmd_ready.
- cmd_ready  out  1  high only in IDLE.
- fifo_rd_en  out  1  pop strobe to FIFO; combinational.
- fifo_rd_data  in  DATA_WIDTH  FIFO registered read data, valid the cycle after an accepted pop.
- fifo_empty  in  1  FIFO empty flag.
- m_data  out  DATA_WIDTH  output word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  final beat of burst (present only with FIFO_RD_LAST_EN).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on burst completion.
- beats_left  out  LEN_WIDTH  output beats not yet accepted in current burst.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: cmd_ready=1. On cmd_valid: if cmd_len==0 go DONE; else load issue_cnt=beats_left=cmd_len, go RUN.
- RUN: fifo_rd_en = issue_cnt!=0 && !fifo_empty && room, where room = (buf_cnt + rd_pend < 2) || (buf_cnt + rd_pend == 2 && m_valid && m_ready).
- Each pop: issue_cnt-1; rd_pend set next cycle; when rd_pend, fifo_rd_data written into skid buffer that edge.
- m_valid = buf_cnt!=0; m_data = buffer head. Handshake (m_valid && m_ready) pops head, beats_left-1.
- Handshake with beats_left==1 → DONE. DONE lasts one cycle (done=1), then IDLE.
- Invariant buf_cnt + rd_pend ≤ 2; the FIFO is never over-popped (issue_cnt bounds pops).
- Buffer write and read in the same cycle: count unchanged, order preserved (FIFO order).
- fifo_empty mid-burst: no pop, engine stalls in RUN; resumes when data arrives. No timeout.
- cmd_valid outside IDLE ignored (cmd_ready=0).

## Timing
- Reset values: cmd_ready=1, fifo_rd_en=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0, beats_left=0; state IDLE, buffer empty, rd_pend=0.
- Command accepted edge T → RUN in cycle T+1; first fifo_rd_en in T+1 if FIFO non-empty; data in FIFO register T+2; m_valid first high T+3.
- Sustained throughput 1 word/cycle with m_ready held high and FIFO non-empty.
- done pulses the cycle after the last handshake; cmd_ready returns high the cycle after done.
- cmd_len==0: done pulse in the cycle after acceptance, no FIFO pops.
- Reset mid-burst: all state cleared immediately; words already popped are lost, so the FIFO shares rst_n.

## Configuration
- FIFO_RD_LAST_EN defined: m_last port exists, asserted with m_valid on the beat where beats_left==1, 0 otherwise.
- Undefined: m_last port and logic absent; burst end signalled only by done.

## Structure
- Package fifo_rd_pkg: state encoding (IDLE/RUN/DONE), SKID_DEPTH=2 constant.
- Sub-module stream_skid_buf: 2-entry DATA_WIDTH buffer with wr, rd, count, head data; top holds FSM, counters, pop gating.

## Test plan
- FIFO preloaded 0x10..0x13, cmd_len=4, m_ready=1 → m_data 0x10,0x11,0x12,0x13 on consecutive cycles, first at T+3, m_last on 0x13, done one cycle later, exactly 4 fifo_rd_en.
- cmd_len=0 → no fifo_rd_en, done pulse T+1, cmd_ready back next cycle.
- 8-word burst, m_ready toggled 1,0,0,1,… → no data loss/duplication, buf_cnt+rd_pend never >2, exactly 8 pops.
- FIFO holds 2 words, cmd_len=5; 3 more words written 20 cycles later → 2 beats, stall with busy=1, remaining 3 beats delivered, done after 5th.
- Reset asserted mid-burst after 3 beats → all outputs to reset values same cycle; new cmd_len=2 after release completes normally.
- cmd_valid held high during RUN → no second burst until after done; cmd_len changes ignored.
